// File: rtl/fifo_pkg.sv
// Shared FIFO constants for the read and write sides.
package fifo_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;
  localparam int FIFO_DW    = 8;
  localparam int FIFO_CW    = FIFO_AW + 1;

  // Occupancy counter width for a given address width (0..DEPTH inclusive).
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_occ_count.sv
// FIFO occupancy counter with status flags decoded from the registered count.
// A write arriving while full and without a read is dropped silently.
module fifo_occ_count
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [AW:0] count,
  output logic        empty,
  output logic        almost_empty,
  output logic        full
);

  localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];
  localparam logic [AW:0] C_ONE   = 1;

  logic [AW:0] r_count;
  logic        w_full;
  logic        w_inc;
  logic        w_dec;

  assign w_full = (r_count == C_DEPTH);
  assign w_inc  = wr_en & ~rd_en & ~w_full;
  assign w_dec  = rd_en & ~wr_en;

  // Track occupancy; simultaneous write and read cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_inc) begin
      r_count <= r_count + C_ONE;
    end else if (w_dec) begin
      r_count <= r_count - C_ONE;
    end
  end

  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign almost_empty = (r_count <= C_ONE);
  assign full         = w_full;

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: read pointer, registered output data and
// optional sticky underflow flag (enabled by macro FIFO_RD_UNDERFLOW_EN).
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          wr_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          almost_empty,
  output logic          full,
  output logic          underflow
);

  localparam logic [AW-1:0] C_ADDR_ONE = 1;

  logic          w_empty;
  logic          w_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_dout;
  logic          r_dout_valid;

  // A read is only accepted against data already counted; no write-through.
  assign w_rd_en = rd & ~w_empty;

  fifo_occ_count #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_occ (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (w_rd_en),
    .count        (count),
    .empty        (w_empty),
    .almost_empty (almost_empty),
    .full         (full)
  );

  // Read pointer advances once per accepted read and wraps at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
    end else if (w_rd_en) begin
      r_rd_addr <= r_rd_addr + C_ADDR_ONE;
    end
  end

  // Capture read data one cycle after acceptance; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_en;
      if (w_rd_en) begin
        r_dout <= mem_rdata;
      end
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic r_underflow;

  // Sticky until reset: any read request seen while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (rd & w_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign underflow = r_underflow;
`else
  assign underflow = 1'b0;
`endif

  assign rd_en      = w_rd_en;
  assign rd_addr    = r_rd_addr;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign empty      = w_empty;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl; the bench acts as write side and memory.
module tb_fifo_read_ctrl;
  import fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;
`ifdef FIFO_RD_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd;
  logic          wr_en;
  logic [DW-1:0] mem_rdata;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [AW:0]   count;
  logic          empty;
  logic          almost_empty;
  logic          full;
  logic          underflow;

  logic [DW-1:0] mem [DEPTH];
  assign mem_rdata = mem[rd_addr];

  always #5 clk = ~clk;

  fifo_read_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd           (rd),
    .wr_en        (wr_en),
    .mem_rdata    (mem_rdata),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .count        (count),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full),
    .underflow    (underflow)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  int            m_count;
  int            m_addr;
  int            m_wptr;
  bit            m_valid;
  logic [DW-1:0] m_dout;
  bit            m_uf;
  logic [DW-1:0] sb [$];

  typedef struct {
    bit            rd;
    bit            wr;
    logic [DW-1:0] d;
    int            e_count;
    int            e_addr;
    bit            e_valid;
    logic [DW-1:0] e_dout;
    bit            e_empty;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count", 32'(count), 32'(m_count));
    chk("rd_addr", 32'(rd_addr), 32'(m_addr));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("almost_empty", 32'(almost_empty), 32'(m_count <= 1));
    chk("full", 32'(full), 32'(m_count == DEPTH));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  task automatic cyc(input bit r, input bit w, input logic [DW-1:0] d);
    bit exp_rden;
    bit wr_ok;
    rst = 1'b0; rd = r; wr_en = w;
    #1;
    exp_rden = r && (m_count != 0);
    chk("rd_en", 32'(rd_en), 32'(exp_rden));
    @(posedge clk);
    #1;
    wr_ok = w && (exp_rden || m_count < DEPTH);
    if (r && m_count == 0) m_uf = UF_EN;
    if (exp_rden) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty actual=read required=data t=%0t", $time);
      end else begin
        m_dout = sb.pop_front();
      end
      m_addr  = (m_addr + 1) % DEPTH;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr_ok) begin
      mem[m_wptr] = d;
      sb.push_back(d);
      m_wptr = (m_wptr + 1) % DEPTH;
    end
    if (wr_ok && !exp_rden) m_count++;
    if (exp_rden && !w) m_count--;
    rd = 1'b0; wr_en = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset(input bit r, input bit w);
    rst = 1'b1; rd = r; wr_en = w;
    @(posedge clk);
    #1;
    rst = 1'b0; rd = 1'b0; wr_en = 1'b0;
    m_count = 0; m_addr = 0; m_wptr = 0;
    m_valid = 1'b0; m_dout = '0; m_uf = 1'b0;
    sb.delete();
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b0, 1'b1, 8'hA1, 1, 0, 1'b0, 8'h00, 1'b0};
    vt[1] = '{1'b0, 1'b1, 8'hB2, 2, 0, 1'b0, 8'h00, 1'b0};
    vt[2] = '{1'b0, 1'b1, 8'hC3, 3, 0, 1'b0, 8'h00, 1'b0};
    vt[3] = '{1'b1, 1'b0, 8'h00, 2, 1, 1'b1, 8'hA1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 8'h00, 1, 2, 1'b1, 8'hB2, 1'b0};
    vt[5] = '{1'b1, 1'b0, 8'h00, 0, 3, 1'b1, 8'hC3, 1'b1};
    vt[6] = '{1'b0, 1'b0, 8'h00, 0, 3, 1'b0, 8'hC3, 1'b1};

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst = 1'b1; rd = 1'b0; wr_en = 1'b0;
    m_count = 0; m_addr = 0; m_wptr = 0; m_valid = 1'b0; m_dout = '0; m_uf = 1'b0;
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // read burst from the vector table
    for (int i = 0; i < 7; i++) begin
      cyc(vt[i].rd, vt[i].wr, vt[i].d);
      chk("tbl_count", 32'(count), 32'(vt[i].e_count));
      chk("tbl_addr", 32'(rd_addr), 32'(vt[i].e_addr));
      chk("tbl_valid", 32'(dout_valid), 32'(vt[i].e_valid));
      chk("tbl_dout", 32'(dout), 32'(vt[i].e_dout));
      chk("tbl_empty", 32'(empty), 32'(vt[i].e_empty));
    end

    // underflow: read while empty, flag sticky across later traffic
    cyc(1'b1, 1'b0, 8'h00);
    chk("uf_set", 32'(underflow), 32'(UF_EN));
    chk("uf_no_valid", 32'(dout_valid), 32'd0);
    cyc(1'b0, 1'b1, 8'h44);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("uf_held", 32'(underflow), 32'(UF_EN));
    do_reset(1'b0, 1'b0);
    chk("uf_cleared", 32'(underflow), 32'd0);

    // write and read together while empty: no write-through
    cyc(1'b1, 1'b1, 8'h5A);
    chk("wr_rd_empty_count", 32'(count), 32'd1);
    cyc(1'b1, 1'b0, 8'h00);
    chk("wr_rd_empty_dout", 32'(dout), 32'h5A);

    // simultaneous write and read at count 5
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h10 + i));
    cyc(1'b1, 1'b1, 8'h77);
    chk("simul_count", 32'(count), 32'd5);
    chk("simul_addr", 32'(rd_addr), 32'd1);
    chk("simul_dout", 32'(dout), 32'h10);

    // wrap-around, twice, with saturation at full
    do_reset(1'b0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      chk("wrap_full", 32'(full), 32'd1);
      chk("wrap_count16", 32'(count), 32'd16);
      cyc(1'b0, 1'b1, 8'hFF);
      chk("sat_count", 32'(count), 32'd16);
      chk("sat_no_uf", 32'(underflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
        cyc(1'b1, 1'b0, 8'h00);
        chk("wrap_not_full", 32'(full), 32'd0);
      end
      chk("wrap_addr0", 32'(rd_addr), 32'd0);
      chk("wrap_empty", 32'(empty), 32'd1);
    end

    // reset in the same cycle as an accepted read
    cyc(1'b0, 1'b1, 8'h31);
    cyc(1'b0, 1'b1, 8'h32);
    cyc(1'b1, 1'b0, 8'h00);
    rst = 1'b1; rd = 1'b1; wr_en = 1'b1;
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd1);
    rst = 1'b0;
    do_reset(1'b1, 1'b1);
    chk("rst_mid_valid", 32'(dout_valid), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries (a power of two, at least 4).
REQ-002 The module SHALL have parameter AW, default 4, meaning the address width, equal to log2(DEPTH).
REQ-003 The module SHALL have parameter DW, default 8, meaning the data width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: a synchronous, active-high reset.
REQ-006 The module SHALL have port rd, input, 1 bit: the consumer's read request.
REQ-007 The module SHALL have port wr_en, input, 1 bit: a write accepted by the write side this cycle.
REQ-008 The module SHALL have port mem_rdata, input, DW bits: the asynchronous memory read data at rd_addr.
REQ-009 The module SHALL have port rd_en, output, 1 bit: the read accepted this cycle.
REQ-010 The module SHALL have port rd_addr, output, AW bits: the read pointer.
REQ-011 The module SHALL have port dout, output, DW bits: the registered read data.
REQ-012 The module SHALL have port dout_valid, output, 1 bit: dout holds fresh data.
REQ-013 The module SHALL have port count, output, AW+1 bits: the occupancy, 0..DEPTH.
REQ-014 The module SHALL have ports empty, almost_empty and full, each an output of 1 bit: the status flags.
REQ-015 The module SHALL have port underflow, output, 1 bit: a sticky flag set by a read attempted while empty.

Function
REQ-016 rd_en SHALL equal rd AND NOT empty, combinationally.
REQ-017 rd_addr SHALL advance by 1 on each rd_en and wrap from DEPTH-1 to 0; it SHALL never move backwards.
REQ-018 count SHALL change as follows: +1 on wr_en without rd_en; -1 on rd_en without wr_en; unchanged on both or neither.
REQ-019 A wr_en with count==DEPTH SHALL be ignored, leaving count saturated, and SHALL NOT set any error flag.
REQ-020 The flags SHALL decode from the registered count: empty = (count==0); full = (count==DEPTH); almost_empty = (count<=1).
REQ-021 When wr_en and rd occur in the same cycle while empty, rd_en SHALL be 0 (no write-through), and count SHALL become 1 on the next cycle.
REQ-022 The latency SHALL be 1 cycle: dout SHALL capture mem_rdata on the edge where rd_en=1, and dout_valid SHALL be 1 for exactly the following cycle per accepted read.
REQ-023 dout SHALL hold its last value when no read is accepted; dout_valid SHALL be 0 in that case.
REQ-024 Back-to-back reads SHALL sustain one word per cycle, with dout_valid held high continuously.

Reset
REQ-025 With rst=1 at a clock edge, rd_addr, count, dout, dout_valid and underflow SHALL become 0, empty and almost_empty SHALL become 1, and full SHALL become 0.
REQ-026 A reset asserted mid-burst SHALL discard any in-flight dout_valid on the same edge, and rd/wr_en SHALL be ignored during that cycle.

Configuration
REQ-027 With FIFO_RD_UNDERFLOW_EN defined, underflow SHALL set on any edge where rd=1 and empty=1, and SHALL clear only on rst.
REQ-028 Without FIFO_RD_UNDERFLOW_EN, underflow SHALL be tied to constant 0 and the module SHALL contain no underflow register.

Structure
REQ-029 DEPTH, AW and DW default constants and the count width SHALL live in shared package fifo_pkg, which is also used by the write side.
REQ-030 The occupancy counter and the flag decode SHALL be one sub-module, fifo_occ_count (inputs wr_en and rd_en; outputs count, empty, almost_empty and full); the pointer and output register stay in fifo_read_ctrl.

Verification
REQ-031 The bench SHALL cover reset: after rst, expect rd_addr=0, count=0, empty=1, almost_empty=1, dout_valid=0 and underflow=0.
REQ-032 The bench SHALL cover a read burst: write 3 words (A1,B2,C3), then hold rd for 3 cycles; expect dout A1,B2,C3 on consecutive cycles with dout_valid high, then count=0 and empty=1.
REQ-033 The bench SHALL cover wrap-around: perform 16 writes and 16 reads twice; expect rd_addr to wrap 15 to 0 and full=1 exactly when count=16.
REQ-034 The bench SHALL cover a simultaneous write and read at count=5; expect count to stay 5 and rd_addr to advance by 1.
REQ-035 The bench SHALL cover underflow: assert rd while empty; expect rd_en=0, no dout_valid, and underflow=1 held until rst (0 when the macro is undefined).
REQ-036 The bench SHALL cover reset mid-read: assert rst in the same cycle as rd_en=1; expect dout_valid=0 and count=0 on the next cycle.
